alu_reserve_station: RTL and testbench
======================================

// Module: alu_reserve_station
// PURPOSE
//  Receiving end of the dispatcher's ALU dispatch interface (alu_ready / alu_index / alu_taken + reserve_station_t).
//  Holds RS_SIZE ALU entries, captures missing operands by snooping the CDB, and issues the oldest fully-ready
//  entry to the ALU pipe under a valid/ack handshake. Sits between decode/dispatch and the ALU function unit.
// PARAMETERS
//  RS_SIZE    4  entries; power of two; index width = $bits(rs_index_t) = $clog2(RS_SIZE)
//  CDB_PORTS  2  number of common-data-bus broadcast ports snooped per cycle
// PORTS
//  clk            in   1                  clock
//  rst            in   1                  reset; synchronous, active-high; one clock
//  flush          in   1                  pipeline flush (mispredict/exception); discard all entries
//  ready          out  1                  at least one free entry (to dispatcher alu_ready)
//  free_index     out  rs_index_t         slot a new entry will occupy (to dispatcher alu_index)
//  taken          in   1                  dispatcher accepted into this RS (alu_taken)
//  rs_in          in   reserve_station_t  entry; written into slot rs_in.index
//  cdb_valid      in   CDB_PORTS          broadcast valid per port
//  cdb_reorder    in   CDB_PORTS x rob_index_t  producing ROB index per port
//  cdb_value      in   CDB_PORTS x 32     result value per port
//  issue_valid    out  1                  issue_entry is a fully-ready entry
//  issue_entry    out  reserve_station_t  entry to execute (operands valid)
//  issue_ack      in   1                  ALU consumed issue_entry this cycle
// BEHAVIOUR
//  Reset/flush: rst or flush clears all busy bits and the age matrix at the next edge; flush beats taken and
//   issue_ack in the same cycle. After reset: ready=1, free_index=0, issue_valid=0, issue_entry='0.
//  State: per entry busy, reserve_station_t payload, operand[1:0], operand_ready[1:0], operand_addr[1:0];
//   age matrix older[i][j] (1 = entry i dispatched before j).
//  ready/free_index: combinational from registered busy only; free_index = lowest-numbered non-busy slot;
//   free_index=0 when full (ready=0 then).
//  Write: on taken & rs_in.busy & ~flush & ~rst, slot rs_in.index <= rs_in, busy<=1; row older[idx][*]<=0,
//   column older[*][idx]<=busy of each other entry after this cycle's issue is removed. Writing a busy slot is a
//   protocol error (assertion), never silently overwrites.
//  Dispatch bypass: if an incoming operand is not ready and any cdb_valid[p] with cdb_reorder[p]==operand_addr
//   in the same cycle, store cdb_value[p] and set ready at write.
//  Wakeup: each cycle, for every busy entry and each operand with operand_ready=0, a matching valid CDB port
//   captures value and sets operand_ready at the edge. Multiple matching ports: lowest port index wins.
//   Operand with operand_ready=1 is never overwritten.
//  Select: candidate = busy & operand_ready[0] & operand_ready[1] (registered state; a woken operand makes its
//   entry selectable the cycle after the CDB broadcast). issue_entry = candidate with no older candidate
//   (age matrix); issue_valid = any candidate. Combinational from registers; no dependence on issue_ack.
//  Issue handshake: issue_valid & issue_ack -> selected entry busy<=0 at the edge; its slot is reported free
//   from the next cycle. issue_entry holds stable while issue_valid & ~issue_ack unless an older entry
//   becomes ready (selection may change; ALU must sample only on ack).
//  Simultaneous: dispatch and issue in one cycle legal (different slots, since free_index comes from registered
//   busy); CDB wakeup and dispatch of consumer same cycle handled by bypass; issue of last entry plus dispatch
//   leaves count unchanged.
//  Latency: dispatch -> earliest issue_valid 1 cycle (operands ready); CDB broadcast -> issue_valid 1 cycle.
//  Widths: operand 32 bit; rob_index_t compare is exact equality, no wrap arithmetic.
// TESTING
//  1 Reset: hold rst 2 cycles -> ready=1, free_index=0, issue_valid=0; dispatch with rst high -> no entry stored.
//  2 Dispatch ADD with both operands ready into slot 0 -> next cycle issue_valid=1, issue_entry.index=0,
//    free_index=1; ack -> slot 0 free next cycle, free_index=0.
//  3 Dispatch op waiting on ROB 5 (op1); cdb_valid[1]=1,cdb_reorder[1]=5,value=0xDEADBEEF two cycles later ->
//    issue_valid rises the following cycle with operand[1]=0xDEADBEEF.
//  4 Same-cycle bypass: dispatch waiting on ROB 3 while CDB port 0 broadcasts ROB 3 = 0x12 -> issue_valid next
//    cycle, operand=0x12.
//  5 Fill all 4 slots (slots 2,0,3,1 become ready in that order, all dispatched 0..3) -> ready=0; with all
//    ready, issue order 0,1,2,3 by age; dispatch while issuing keeps ready tracking occupancy.
//  6 Flush with 3 busy entries, taken=1 and issue_ack=1 same cycle -> next cycle all empty, issue_valid=0,
//    ready=1, free_index=0.

Source files
------------

// File: rtl/alu_reserve_station.sv
// ALU reservation station: holds dispatched ALU ops, snoops the CDB for missing
// operands and issues the oldest fully-ready entry under a valid/ack handshake.

package alu_rs_pkg;
    localparam int RS_ENTRIES = 4;
    localparam int ROB_SIZE   = 16;

    typedef logic [$clog2(RS_ENTRIES)-1:0] rs_index_t;
    typedef logic [$clog2(ROB_SIZE)-1:0]   rob_index_t;
    typedef logic [3:0]                    alu_op_t;

    typedef struct packed {
        logic                   busy;
        rs_index_t              index;
        alu_op_t                op;
        rob_index_t             reorder;
        logic [1:0][31:0]       operand;
        logic [1:0]             operand_ready;
        rob_index_t [1:0]       operand_addr;
    } reserve_station_t;
endpackage

module alu_reserve_station
    import alu_rs_pkg::*;
#(
    // Must match alu_rs_pkg::RS_ENTRIES, which sizes rs_index_t.
    parameter int RS_SIZE   = RS_ENTRIES,
    parameter int CDB_PORTS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    output logic                            ready,
    output rs_index_t                       free_index,
    input  logic                            taken,
    input  reserve_station_t                rs_in,
    input  logic [CDB_PORTS-1:0]            cdb_valid,
    input  rob_index_t [CDB_PORTS-1:0]      cdb_reorder,
    input  logic [CDB_PORTS-1:0][31:0]      cdb_value,
    output logic                            issue_valid,
    output reserve_station_t                issue_entry,
    input  logic                            issue_ack
);

    logic [RS_SIZE-1:0]              busy_q, busy_d;
    reserve_station_t                entry_q [RS_SIZE];
    reserve_station_t                entry_d [RS_SIZE];
    // older_q[i][j] = 1 when entry i was dispatched before entry j.
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q, older_d;

    logic [RS_SIZE-1:0] candidate;
    logic [RS_SIZE-1:0] select;
    logic [RS_SIZE-1:0] issue_clr;
    logic [RS_SIZE-1:0] busy_after_issue;
    logic               wr_en;
    rs_index_t          wr_idx;

    // Capture any not-yet-ready operand from the CDB; the loop runs from the
    // highest port down so the lowest matching port is the final assignment.
    function automatic reserve_station_t snoop(input reserve_station_t e);
        reserve_station_t r;
        r = e;
        for (int k = 0; k < 2; k++) begin
            if (!e.operand_ready[k]) begin
                for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                    if (cdb_valid[p] && (cdb_reorder[p] == e.operand_addr[k])) begin
                        r.operand[k]       = cdb_value[p];
                        r.operand_ready[k] = 1'b1;
                    end
                end
            end
        end
        return r;
    endfunction

    // Free-slot report: lowest non-busy slot, 0 when full.
    always_comb begin
        free_index = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_index = rs_index_t'(i);
            end
        end
    end

    assign ready = ~(&busy_q);

    // Select the oldest candidate: a candidate is picked when no other
    // candidate is marked older than it in the age matrix.
    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_sel
        logic [RS_SIZE-1:0] older_col;
        for (genvar gj = 0; gj < RS_SIZE; gj++) begin : g_col
            assign older_col[gj] = older_q[gj][gi];
        end
        assign candidate[gi] = busy_q[gi] & (&entry_q[gi].operand_ready);
        assign select[gi]    = candidate[gi] & ~(|(candidate & older_col));
    end

    assign issue_valid      = |candidate;
    assign issue_clr        = select & {RS_SIZE{issue_valid & issue_ack}};
    assign busy_after_issue = busy_q & ~issue_clr;

    // Output mux over the one-hot selection; zero when nothing is selectable.
    always_comb begin
        issue_entry = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (select[i]) begin
                issue_entry = entry_q[i];
            end
        end
    end

    // A write into an occupied slot is dropped rather than clobbering it.
    assign wr_idx = rs_in.index;
    assign wr_en  = taken & rs_in.busy & ~flush & ~rst & ~busy_q[wr_idx];

    // Per-entry payload next state: new dispatch (with bypass) or wakeup.
    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
        assign entry_d[gi] = (wr_en && (wr_idx == rs_index_t'(gi))) ? snoop(rs_in) :
                             (busy_q[gi] ? snoop(entry_q[gi]) : entry_q[gi]);
    end

    // Occupancy and age-matrix next state; flush discards everything.
    always_comb begin
        busy_d  = busy_after_issue;
        older_d = older_q;
        if (wr_en) begin
            busy_d[wr_idx] = 1'b1;
            for (int j = 0; j < RS_SIZE; j++) begin
                older_d[wr_idx][j] = 1'b0;
            end
            for (int j = 0; j < RS_SIZE; j++) begin
                older_d[j][wr_idx] = busy_after_issue[j];
            end
        end
        if (flush) begin
            busy_d  = '0;
            older_d = '0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            older_q <= '0;
        end else begin
            busy_q  <= busy_d;
            older_q <= older_d;
        end
    end

    // Payload registers; contents are qualified by busy_q so need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entry_q[i] <= entry_d[i];
        end
    end

    // Dispatcher must only target a free slot.
    a_no_overwrite: assert property (@(posedge clk) disable iff (rst || flush)
        !(taken && rs_in.busy && busy_q[rs_in.index]));

endmodule

// File: tb/tb_alu_reserve_station.sv
// Directed self-checking bench for alu_reserve_station.
module tb_alu_reserve_station;
    import alu_rs_pkg::*;

    localparam int CDB_PORTS = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        flush;
    logic                        ready;
    rs_index_t                   free_index;
    logic                        taken;
    reserve_station_t            rs_in;
    logic [CDB_PORTS-1:0]        cdb_valid;
    rob_index_t [CDB_PORTS-1:0]  cdb_reorder;
    logic [CDB_PORTS-1:0][31:0]  cdb_value;
    logic                        issue_valid;
    reserve_station_t            issue_entry;
    logic                        issue_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_reserve_station #(.RS_SIZE(4), .CDB_PORTS(CDB_PORTS)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .ready       (ready),
        .free_index  (free_index),
        .taken       (taken),
        .rs_in       (rs_in),
        .cdb_valid   (cdb_valid),
        .cdb_reorder (cdb_reorder),
        .cdb_value   (cdb_value),
        .issue_valid (issue_valid),
        .issue_entry (issue_entry),
        .issue_ack   (issue_ack)
    );

    function automatic reserve_station_t mk(input rs_index_t idx,
                                            input logic [31:0] v0, input logic r0, input rob_index_t a0,
                                            input logic [31:0] v1, input logic r1, input rob_index_t a1);
        reserve_station_t e;
        e                  = '0;
        e.busy             = 1'b1;
        e.index            = idx;
        e.op               = 4'h1;
        e.reorder          = 4'hF;
        e.operand[0]       = v0;
        e.operand_ready[0] = r0;
        e.operand_addr[0]  = a0;
        e.operand[1]       = v1;
        e.operand_ready[1] = r1;
        e.operand_addr[1]  = a1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        taken       = 1'b0;
        rs_in       = '0;
        cdb_valid   = '0;
        cdb_reorder = '0;
        cdb_value   = '0;
        issue_ack   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst   = 1'b1;
        taken = 1'b1;
        rs_in = mk(2'd0, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0);
        tick();
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", ready); end
        checks++; if (free_index !== 2'd0) begin errors++; $display("FAIL reset_free_index got %0d exp 0", free_index); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %0b exp 0", issue_valid); end
        checks++; if (issue_entry !== reserve_station_t'('0)) begin errors++; $display("FAIL reset_issue_entry got %h exp 0", issue_entry); end
        rst = 1'b0;
        idle_inputs();
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_no_store got issue_valid %0b exp 0", issue_valid); end
        checks++; if (free_index !== 2'd0) begin errors++; $display("FAIL reset_no_store_free got %0d exp 0", free_index); end
        $display("reset done");
    endtask

    task automatic test_dispatch_issue();
        taken = 1'b1;
        rs_in = mk(2'd0, 32'd7, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0);
        tick();
        idle_inputs();
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL disp_issue_valid got %0b exp 1", issue_valid); end
        checks++; if (issue_entry.index !== 2'd0) begin errors++; $display("FAIL disp_index got %0d exp 0", issue_entry.index); end
        checks++; if (issue_entry.operand[0] !== 32'd7) begin errors++; $display("FAIL disp_op0 got %h exp 7", issue_entry.operand[0]); end
        checks++; if (issue_entry.operand[1] !== 32'd9) begin errors++; $display("FAIL disp_op1 got %h exp 9", issue_entry.operand[1]); end
        checks++; if (free_index !== 2'd1) begin errors++; $display("FAIL disp_free_index got %0d exp 1", free_index); end
        issue_ack = 1'b1;
        tick();
        idle_inputs();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL disp_after_ack_valid got %0b exp 0", issue_valid); end
        checks++; if (free_index !== 2'd0) begin errors++; $display("FAIL disp_after_ack_free got %0d exp 0", free_index); end
        $display("dispatch/issue slot 0 done");
    endtask

    task automatic test_wakeup();
        taken = 1'b1;
        rs_in = mk(2'd0, 32'h11, 1'b1, 4'd5, 32'h0, 1'b0, 4'd5);
        tick();
        idle_inputs();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_wait1 got %0b exp 0", issue_valid); end
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_wait2 got %0b exp 0", issue_valid); end
        cdb_valid      = 2'b11;
        cdb_reorder[0] = 4'd6;
        cdb_value[0]   = 32'h00000BAD;
        cdb_reorder[1] = 4'd5;
        cdb_value[1]   = 32'hDEADBEEF;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_bcast_cycle got %0b exp 0", issue_valid); end
        tick();
        idle_inputs();
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL wake_valid got %0b exp 1", issue_valid); end
        checks++; if (issue_entry.operand[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL wake_op1 got %h exp deadbeef", issue_entry.operand[1]); end
        checks++; if (issue_entry.operand[0] !== 32'h11) begin errors++; $display("FAIL wake_op0_kept got %h exp 11", issue_entry.operand[0]); end
        issue_ack = 1'b1;
        tick();
        idle_inputs();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_drain got %0b exp 0", issue_valid); end
        $display("wakeup ROB 5 done");
    endtask

    task automatic test_bypass();
        taken          = 1'b1;
        rs_in          = mk(2'd0, 32'h0, 1'b0, 4'd3, 32'h5, 1'b1, 4'd0);
        cdb_valid      = 2'b11;
        cdb_reorder[0] = 4'd3;
        cdb_value[0]   = 32'h12;
        cdb_reorder[1] = 4'd3;
        cdb_value[1]   = 32'h99;
        tick();
        idle_inputs();
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got %0b exp 1", issue_valid); end
        checks++; if (issue_entry.operand[0] !== 32'h12) begin errors++; $display("FAIL bypass_op0 got %h exp 12", issue_entry.operand[0]); end
        issue_ack = 1'b1;
        tick();
        idle_inputs();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL bypass_drain got %0b exp 0", issue_valid); end
        $display("bypass ROB 3 done");
    endtask

    task automatic test_fill_age();
        int order [4];
        int exp_sel [4];
        order   = '{2, 0, 3, 1};
        exp_sel = '{2, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            checks++; if (free_index !== rs_index_t'(i)) begin errors++; $display("FAIL fill_free_%0d got %0d exp %0d", i, free_index, i); end
            taken = 1'b1;
            rs_in = mk(rs_index_t'(i), 32'(i), 1'b1, 4'd0, 32'h0, 1'b0, rob_index_t'(10 + i));
            tick();
            idle_inputs();
            $display("dispatch slot %0d waiting on ROB %0d", i, 10 + i);
        end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %0b exp 0", ready); end
        checks++; if (free_index !== 2'd0) begin errors++; $display("FAIL fill_full_free got %0d exp 0", free_index); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL fill_none_ready got %0b exp 0", issue_valid); end
        for (int k = 0; k < 4; k++) begin
            cdb_valid      = 2'b01;
            cdb_reorder[0] = rob_index_t'(10 + order[k]);
            cdb_value[0]   = 32'h100 + 32'(order[k]);
            tick();
            idle_inputs();
            checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL age_valid_%0d got %0b exp 1", k, issue_valid); end
            checks++; if (issue_entry.index !== rs_index_t'(exp_sel[k])) begin errors++; $display("FAIL age_sel_%0d got %0d exp %0d", k, issue_entry.index, exp_sel[k]); end
            $display("wake slot %0d, selected %0d", order[k], issue_entry.index);
        end
        checks++; if (issue_entry.operand[1] !== 32'h100) begin errors++; $display("FAIL age_op1_slot0 got %h exp 100", issue_entry.operand[1]); end
        issue_ack = 1'b1;
        tick();
        idle_inputs();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL age_ready_after0 got %0b exp 1", ready); end
        checks++; if (free_index !== 2'd0) begin errors++; $display("FAIL age_free_after0 got %0d exp 0", free_index); end
        checks++; if (issue_entry.index !== 2'd1) begin errors++; $display("FAIL age_next1 got %0d exp 1", issue_entry.index); end
        // Issue slot 1 while dispatching a new, youngest entry into slot 0.
        issue_ack = 1'b1;
        taken     = 1'b1;
        rs_in     = mk(2'd0, 32'hA, 1'b1, 4'd0, 32'hB, 1'b1, 4'd0);
        tick();
        idle_inputs();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL simul_ready got %0b exp 1", ready); end
        checks++; if (free_index !== 2'd1) begin errors++; $display("FAIL simul_free got %0d exp 1", free_index); end
        checks++; if (issue_entry.index !== 2'd2) begin errors++; $display("FAIL simul_next2 got %0d exp 2", issue_entry.index); end
        issue_ack = 1'b1;
        tick();
        idle_inputs();
        checks++; if (issue_entry.index !== 2'd3) begin errors++; $display("FAIL age_next3 got %0d exp 3", issue_entry.index); end
        issue_ack = 1'b1;
        tick();
        idle_inputs();
        checks++; if (issue_entry.index !== 2'd0) begin errors++; $display("FAIL age_young0 got %0d exp 0", issue_entry.index); end
        checks++; if (issue_entry.operand[0] !== 32'hA) begin errors++; $display("FAIL age_young_op0 got %h exp a", issue_entry.operand[0]); end
        issue_ack = 1'b1;
        tick();
        idle_inputs();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL age_drain got %0b exp 0", issue_valid); end
        $display("age order test done");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            taken = 1'b1;
            rs_in = mk(rs_index_t'(i), 32'h20 + 32'(i), 1'b1, 4'd0, 32'h0, 1'b1, 4'd0);
            tick();
            idle_inputs();
        end
        checks++; if (free_index !== 2'd3) begin errors++; $display("FAIL flush_pre_free got %0d exp 3", free_index); end
        flush     = 1'b1;
        taken     = 1'b1;
        rs_in     = mk(2'd3, 32'h1, 1'b1, 4'd0, 32'h2, 1'b1, 4'd0);
        issue_ack = 1'b1;
        tick();
        idle_inputs();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", issue_valid); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", ready); end
        checks++; if (free_index !== 2'd0) begin errors++; $display("FAIL flush_free got %0d exp 0", free_index); end
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty got %0b exp 0", issue_valid); end
        $display("flush done");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_dispatch_issue();
        test_wakeup();
        test_bypass();
        test_fill_age();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
